// File: rtl/score_accumulator.sv
// Per-hand score keeper: each accepted card adds its value mod 10 to its hand.
// One card per cycle; state, accept and err all appear one cycle after the accepting edge.
module score_accumulator #(
  parameter int NUM_HANDS = 2,
  parameter int MAX_CARDS = 3,
  localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
  localparam int CW = $clog2(MAX_CARDS + 1)
) (
  input  logic                    slow_clock,
  input  logic                    reset,
  input  logic                    card_valid,
  input  logic [HW-1:0]           card_hand,
  input  logic [3:0]              card,
  input  logic [NUM_HANDS-1:0]    clear_hand,
  output logic                    card_ready,
  output logic [4*NUM_HANDS-1:0]  total,
  output logic [CW*NUM_HANDS-1:0] count,
  output logic [NUM_HANDS-1:0]    full,
  output logic [NUM_HANDS-1:0]    natural,
  output logic                    accept,
  output logic                    err
);

  logic [NUM_HANDS-1:0][3:0]    total_q, total_d;
  logic [NUM_HANDS-1:0][CW-1:0] count_q, count_d;
  logic [NUM_HANDS-1:0]         full_d, natural_d;
  logic [NUM_HANDS-1:0]         hit;
  logic                         sel_full, sel_clear;
  logic                         legal, take;
  logic [3:0]                   value;
  logic [4:0]                   sum;

  // An out-of-range card_hand matches no hand, so hit stays zero and the card is refused.
  always_comb begin
    hit       = '0;
    sel_full  = 1'b0;
    sel_clear = 1'b0;
    for (int i = 0; i < NUM_HANDS; i++) begin
      if (card_hand == HW'(i)) begin
        hit[i]    = 1'b1;
        sel_full  = full[i];
        sel_clear = clear_hand[i];
      end
    end
  end

  // A hand being cleared on this edge counts as empty, so it can take a card even if full.
  assign card_ready = (|hit) && (!sel_full || sel_clear);
  assign legal      = (card >= 4'd1) && (card <= 4'd13);
  assign value      = (card <= 4'd9) ? card : 4'd0;
  assign take       = card_valid && card_ready && legal;

  always_comb begin
    total_d   = total_q;
    count_d   = count_q;
    full_d    = '0;
    natural_d = '0;
    sum       = '0;
    for (int i = 0; i < NUM_HANDS; i++) begin
      if (clear_hand[i]) begin
        total_d[i] = '0;
        count_d[i] = '0;
      end
      if (take && hit[i]) begin
        sum        = {1'b0, total_d[i]} + {1'b0, value};
        total_d[i] = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
        if (count_d[i] != CW'(MAX_CARDS))
          count_d[i] = count_d[i] + CW'(1);
      end
      full_d[i]    = (count_d[i] == CW'(MAX_CARDS));
      natural_d[i] = (count_d[i] == CW'(2)) && (total_d[i] >= 4'd8);
    end
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      total_q <= '0;
      count_q <= '0;
      full    <= '0;
      natural <= '0;
      accept  <= 1'b0;
      err     <= 1'b0;
    end else begin
      total_q <= total_d;
      count_q <= count_d;
      full    <= full_d;
      natural <= natural_d;
      accept  <= take;
      err     <= card_valid && !take;
    end
  end

  assign total = total_q;
  assign count = count_q;

endmodule

// File: tb/tb_score_accumulator.sv
// Scoreboard bench for score_accumulator over several NUM_HANDS/MAX_CARDS combinations.
// Expected results come from a per-hand sum-mod-10 model; a monitor checks each pulse.
module tb_score_accumulator;

  typedef struct packed {
    logic [31:0] cyc;
    logic        acc;
    logic        err;
    logic [15:0] tot;
    logic [15:0] cnt;
  } rec_t;

  logic slow_clock;
  int   cyc;
  int   checks;
  int   errors;
  logic all_done;

  initial begin
    slow_clock = 1'b0;
    forever #5 slow_clock = ~slow_clock;
  end

  initial cyc = 0;
  always @(posedge slow_clock) cyc <= cyc + 1;

  initial begin
    checks = 0;
    errors = 0;
  end

  task automatic chk(input int cfg, input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %0d expected %0d (t=%0t)", cfg, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 5; g++) begin : cfg
    localparam int NH = (g == 0) ? 3 : (g <= 2) ? 1 : 4;
    localparam int MC = (g == 0) ? 3 : (g % 2 == 1) ? 2 : 15;
    localparam int HW = (NH > 1) ? $clog2(NH) : 1;
    localparam int CW = $clog2(MC + 1);

    logic              reset, card_valid, card_ready, accept, err;
    logic [HW-1:0]     card_hand;
    logic [3:0]        card;
    logic [NH-1:0]     clear_hand, full, natural;
    logic [4*NH-1:0]   total;
    logic [CW*NH-1:0]  count;
    logic              done_l;
    int                m_tot[4];
    int                m_cnt[4];
    rec_t              q[$];

    score_accumulator #(.NUM_HANDS(NH), .MAX_CARDS(MC)) dut (
      .slow_clock (slow_clock),
      .reset      (reset),
      .card_valid (card_valid),
      .card_hand  (card_hand),
      .card       (card),
      .clear_hand (clear_hand),
      .card_ready (card_ready),
      .total      (total),
      .count      (count),
      .full       (full),
      .natural    (natural),
      .accept     (accept),
      .err        (err)
    );

    function automatic int tot(input int h);
      return int'(total[4*h +: 4]);
    endfunction

    function automatic int cnt(input int h);
      return int'(count[CW*h +: CW]);
    endfunction

    // Drive one cycle of stimulus, advance the model, return #1 after the edge.
    task automatic issue(input bit rst, input bit v, input int hand, input int cd, input int clr_in);
      rec_t r;
      bit   rdy, acc;
      int   clr;
      clr        = clr_in & ((1 << NH) - 1);
      reset      = rst;
      card_valid = v;
      card_hand  = HW'(hand);
      card       = 4'(cd);
      clear_hand = NH'(clr);
      #1;
      if (rst) begin
        for (int h = 0; h < 4; h++) begin
          m_tot[h] = 0;
          m_cnt[h] = 0;
        end
      end else begin
        rdy = 1'b0;
        if (hand < NH) rdy = (m_cnt[hand] < MC) || clr[hand];
        chk(g, "card_ready", card_ready, rdy);
        acc = v && rdy && (cd >= 1) && (cd <= 13);
        for (int h = 0; h < NH; h++) begin
          if (clr[h]) begin
            m_tot[h] = 0;
            m_cnt[h] = 0;
          end
        end
        if (acc) begin
          m_tot[hand] = (m_tot[hand] + ((cd <= 9) ? cd : 0)) % 10;
          m_cnt[hand] = m_cnt[hand] + 1;
        end
        if (v) begin
          r     = '0;
          r.cyc = 32'(cyc + 1);
          r.acc = acc;
          r.err = !acc;
          for (int h = 0; h < NH; h++) begin
            r.tot[4*h +: 4] = 4'(m_tot[h]);
            r.cnt[4*h +: 4] = 4'(m_cnt[h]);
          end
          q.push_back(r);
        end
      end
      @(posedge slow_clock);
      #1;
    endtask

    task automatic run_random(input int n);
      int hand, cd, clr, clr_odds;
      bit rst, v;
      clr_odds = (MC > 3) ? 64 : 12;
      for (int i = 0; i < n; i++) begin
        rst  = ($urandom_range(0, 199) == 0);
        v    = ($urandom_range(0, 3) != 0);
        hand = int'($urandom_range(0, (1 << HW) - 1));
        cd   = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 15))
                                            : int'($urandom_range(1, 13));
        clr  = ($urandom_range(0, clr_odds - 1) == 0) ? int'($urandom_range(0, 15)) : 0;
        issue(rst, v, hand, cd, clr);
      end
      issue(0, 0, 0, 0, 0);
      issue(0, 0, 0, 0, 0);
      chk(g, "queue_drained", q.size(), 0);
    endtask

    always @(negedge slow_clock) begin
      rec_t r;
      if (q.size() > 0 && int'(q[0].cyc) < cyc) begin
        chk(g, "stale_expectation", int'(q[0].cyc), cyc);
        void'(q.pop_front());
      end
      if (accept || err) begin
        chk(g, "accept_err_exclusive", accept && err, 0);
        if (q.size() == 0 || int'(q[0].cyc) != cyc) begin
          chk(g, "unexpected_pulse", 1, 0);
        end else begin
          r = q.pop_front();
          chk(g, "accept", accept, r.acc);
          chk(g, "err", err, r.err);
          for (int h = 0; h < NH; h++) begin
            chk(g, $sformatf("total%0d", h), tot(h), r.tot[4*h +: 4]);
            chk(g, $sformatf("count%0d", h), cnt(h), r.cnt[4*h +: 4]);
            chk(g, $sformatf("full%0d", h), full[h], int'(r.cnt[4*h +: 4]) == MC);
            chk(g, $sformatf("natural%0d", h), natural[h],
                (r.cnt[4*h +: 4] == 4'd2) && (r.tot[4*h +: 4] >= 4'd8));
          end
        end
      end else if (q.size() > 0 && int'(q[0].cyc) == cyc) begin
        chk(g, "missing_pulse", 0, 1);
        void'(q.pop_front());
      end
    end

    if (g == 0) begin : g_dir
      task automatic directed();
        issue(1, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0);
        chk(g, "rst_total", total, 0);
        chk(g, "rst_count", count, 0);
        chk(g, "rst_full", full, 0);
        chk(g, "rst_natural", natural, 0);
        chk(g, "rst_pulses", {accept, err}, 0);

        issue(0, 1, 0, 7, 0);
        chk(g, "c7_accept", accept, 1);
        chk(g, "c7_total0", tot(0), 7);
        issue(0, 1, 0, 8, 0);
        chk(g, "c78_total0", tot(0), 5);
        chk(g, "c78_count0", cnt(0), 2);
        chk(g, "c78_natural0", natural[0], 0);
        chk(g, "c78_accept", accept, 1);
        chk(g, "c78_total1", tot(1), 0);

        issue(0, 1, 1, 13, 0);
        issue(0, 1, 1, 9, 0);
        chk(g, "k9_total1", tot(1), 9);
        chk(g, "k9_natural1", natural[1], 1);
        issue(0, 1, 1, 5, 0);
        chk(g, "k95_total1", tot(1), 4);
        chk(g, "k95_count1", cnt(1), 3);
        chk(g, "k95_full1", full[1], 1);
        chk(g, "k95_natural1", natural[1], 0);
        card_hand = 2'd1;
        #1;
        chk(g, "full_not_ready", card_ready, 0);

        issue(0, 1, 1, 2, 0);
        chk(g, "full_err", {accept, err}, 1);
        chk(g, "full_total1", tot(1), 4);
        chk(g, "full_count1", cnt(1), 3);
        issue(0, 1, 0, 0, 0);
        chk(g, "code0_err", {accept, err}, 1);
        issue(0, 1, 0, 15, 0);
        chk(g, "code15_err", {accept, err}, 1);
        chk(g, "code15_total0", tot(0), 5);
        chk(g, "code15_count0", cnt(0), 2);
        issue(0, 1, 3, 5, 0);
        chk(g, "hand3_err", {accept, err}, 1);
        chk(g, "hand3_totals", total, 12'h045);

        issue(0, 1, 1, 6, 2);
        chk(g, "clrcard_total1", tot(1), 6);
        chk(g, "clrcard_count1", cnt(1), 1);
        chk(g, "clrcard_full1", full[1], 0);
        chk(g, "clrcard_pulses", {accept, err}, 2);

        issue(0, 1, 2, 4, 1);
        chk(g, "cross_total0", tot(0), 0);
        chk(g, "cross_count0", cnt(0), 0);
        chk(g, "cross_total2", tot(2), 4);

        issue(0, 1, 0, 2, 0);
        issue(0, 1, 0, 3, 0);
        issue(1, 1, 0, 5, 7);
        chk(g, "midrst_total", total, 0);
        chk(g, "midrst_count", count, 0);
        chk(g, "midrst_flags", {full, natural}, 0);
        chk(g, "midrst_pulses", {accept, err}, 0);
        issue(0, 1, 0, 3, 0);
        chk(g, "after_rst_total0", tot(0), 3);
        chk(g, "after_rst_count0", cnt(0), 1);
      endtask

      initial begin
        done_l = 1'b0;
        reset = 1'b1; card_valid = 1'b0; card_hand = '0; card = '0; clear_hand = '0;
        @(posedge slow_clock);
        #1;
        directed();
        run_random(600);
        done_l = 1'b1;
      end
    end else begin : g_rnd
      initial begin
        done_l = 1'b0;
        reset = 1'b1; card_valid = 1'b0; card_hand = '0; card = '0; clear_hand = '0;
        @(posedge slow_clock);
        #1;
        issue(1, 0, 0, 0, 0);
        run_random(800);
        done_l = 1'b1;
      end
    end
  end

  assign all_done = cfg[0].done_l & cfg[1].done_l & cfg[2].done_l & cfg[3].done_l & cfg[4].done_l;

  initial begin
    for (int i = 0; i < 20000; i++) begin
      @(posedge slow_clock);
      if (all_done) break;
    end
    #2;
    chk(-1, "all_done", all_done, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_accumulator.md
SCORE_ACCUMULATOR -- requirements
Module: score_accumulator

Interface
REQ-001 The block SHALL have parameter NUM_HANDS, default 2: number of independent hands (>=1; hand 0 = player, hand 1 = dealer).
REQ-002 The block SHALL have parameter MAX_CARDS, default 3: maximum cards per hand (2..15).
REQ-003 HW SHALL be max(1, clog2(NUM_HANDS)) and CW SHALL be clog2(MAX_CARDS+1); both are derived, not user parameters.
REQ-004 The block SHALL have port slow_clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port card_valid, input, 1 bit: a card is presented this cycle.
REQ-007 The block SHALL have port card_hand, input, HW bits: target hand index.
REQ-008 The block SHALL have port card, input, 4 bits: card code, 1=A, 2..10 pip, 11=J, 12=Q, 13=K.
REQ-009 The block SHALL have port clear_hand, input, NUM_HANDS bits: per-hand clear request, one bit per hand.
REQ-010 The block SHALL have port card_ready, output, 1 bit: combinational; 1 when card_hand < NUM_HANDS and that hand is not full.
REQ-011 The block SHALL have port total, output, 4*NUM_HANDS bits: registered score per hand, hand i in bits [4i+3:4i], range 0..9.
REQ-012 The block SHALL have port count, output, CW*NUM_HANDS bits: registered number of accepted cards per hand.
REQ-013 The block SHALL have port full, output, NUM_HANDS bits: registered; bit i = (count_i == MAX_CARDS).
REQ-014 The block SHALL have port natural, output, NUM_HANDS bits: registered; bit i = (count_i == 2 and total_i >= 8).
REQ-015 The block SHALL have port accept, output, 1 bit: registered one-cycle pulse; a card was accepted on the previous edge.
REQ-016 The block SHALL have port err, output, 1 bit: registered one-cycle pulse; a card was rejected on the previous edge.

Function
REQ-017 Card value SHALL be: card for codes 1..9; 0 for codes 10..13.
REQ-018 Codes 0, 14 and 15 SHALL be illegal.
REQ-019 A card SHALL be accepted on an edge where card_valid=1, card_ready=1 and the code is legal.
REQ-020 On accept, the target hand SHALL update: total <= (total + value) mod 10, computed as a 5-bit sum minus 10 when the sum >= 10; count <= count + 1.
REQ-021 Latency SHALL be one cycle: the updated total/count/full/natural and the accept pulse are visible the cycle after the accepting edge.
REQ-022 On an edge where card_valid=1 but the card is not accepted (illegal code, hand index out of range, or hand full), err SHALL pulse for one cycle and all hand state SHALL remain unchanged.
REQ-023 accept and err SHALL never both be 1, and both SHALL be 0 on any cycle not following a card_valid edge.
REQ-024 When clear_hand[i]=1, hand i SHALL set total_i <= 0 and count_i <= 0 on that edge; other hands are unaffected.
REQ-025 When clear_hand[i]=1 and a legal card_valid targets hand i on the same edge, the hand SHALL restart holding that card: total = value, count = 1, accept pulses.
REQ-026 For the same-edge clear of REQ-025, card_ready SHALL be evaluated as if hand i were empty, so a card sent to a full hand being cleared is accepted.
REQ-027 Clearing one hand while a card is accepted into another hand SHALL apply both updates on the same edge.
REQ-028 count SHALL saturate at MAX_CARDS and SHALL never wrap.
REQ-029 No sequence of inputs SHALL produce total > 9.
REQ-030 The block SHALL hold at most one card per cycle and SHALL have no internal buffering: a rejected card is dropped, and resubmission is the caller's job.

Reset
REQ-031 While reset=1 at an edge, all totals and counts SHALL become 0, and full, natural, accept and err SHALL become 0.
REQ-032 reset SHALL override card_valid and clear_hand on the same edge: no accept or err pulse is produced for that edge.
REQ-033 Reset asserted mid-hand SHALL discard all accumulated cards; the first card after reset is the first card of a new hand.

Verification
REQ-034 Reset then hand0 cards 7, 8 -> total0=5, count0=2, natural0=0; accept pulses each following cycle; total1=0.
REQ-035 Hand1 cards 13, 9 -> total1=9, natural1=1; then card 5 -> total1=4, count1=3, full1=1, natural1=0, card_ready=0 for hand1.
REQ-036 Fourth card 2 to full hand1, then codes 0 and 15 to hand0, then card_hand=3 (NUM_HANDS=2, HW=1 not applicable; run with NUM_HANDS=3) -> err pulses each time; all totals and counts unchanged.
REQ-037 Hand1 full (total 4), clear_hand=2'b10 together with card 6 to hand1 -> total1=6, count1=1, full1=0, accept=1, err=0.
REQ-038 Reset asserted with card_valid=1 after two cards in hand0 -> all outputs 0, no accept or err; next card 3 -> total0=3, count0=1.
REQ-039 Parameter sweep NUM_HANDS=1 and 4, MAX_CARDS=2 and 15: random legal streams checked against a reference model of sum mod 10 per hand, including MAX_CARDS saturation.
